// File: rtl/pipe_skid_if.sv
// pipe_skid_if: ready/valid handshake bundle for pipe_skid_reg.
//   in_valid/in_data/in_ready     upstream write channel
//   out_valid/out_data/out_ready  downstream read channel
//   occupancy                     number of words held by the register (0..2)
// Modports: slave = register side, master = driver/consumer side.
interface pipe_skid_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic [1:0]       occupancy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, occupancy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, occupancy
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry ready/valid pipeline register (main + skid).
// Sustains one transfer per cycle each way; every output comes straight from a
// flop, so a downstream stall never forms a combinational ready path upstream.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous reset, active-high
//   flush  synchronous discard of all held words (beats any transfer)
//   bus    pipe_skid_if.slave handshake bundle (in_*, out_*, occupancy)
//
// state | meaning
// EMPTY | no word held, in_ready=1, out_valid=0
// ONE   | main holds the oldest word, in_ready=1, out_valid=1
// FULL  | main + skid hold two words, in_ready=0, out_valid=1
module pipe_skid_reg #(
   parameter int WIDTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   pipe_skid_if.slave  bus
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             out_valid_q;
   logic             in_ready_q;
   logic [1:0]       occ_q;

   logic in_fire;
   logic out_fire;

   // Fires use the registered handshake outputs, never a derived ready.
   assign in_fire  = bus.in_valid & in_ready_q;
   assign out_fire = out_valid_q & bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else if (flush) begin
         // Data registers keep their contents; only the bookkeeping empties.
         state       <= EMPTY;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         occ_q       <= 2'd0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state       <= ONE;
                  main_q      <= bus.in_data;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
                  occ_q       <= 2'd1;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= bus.in_data;
               end else if (in_fire) begin
                  state       <= FULL;
                  skid_q      <= bus.in_data;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b0;
                  occ_q       <= 2'd2;
               end else if (out_fire) begin
                  state       <= EMPTY;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  occ_q       <= 2'd0;
               end
            end
            FULL: begin
               // in_ready is low here, so only the drain path exists.
               if (out_fire) begin
                  state       <= ONE;
                  main_q      <= skid_q;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
                  occ_q       <= 2'd1;
               end
            end
            default: begin
               state       <= EMPTY;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               occ_q       <= 2'd0;
            end
         endcase
      end
   end

   assign bus.out_data  = main_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: self-checking bench for pipe_skid_reg.
// A plain FIFO queue (capacity 2) predicts occupancy, handshake outputs and the
// word at the head; directed scenarios add fixed-value checks on top.
module tb_pipe_skid_reg;

   logic clk;
   logic rst;
   logic flush;

   pipe_skid_if #(.WIDTH(8)) bus ();

   pipe_skid_reg #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
      if (q.size() > 0) chk("out_data", 32'(bus.out_data), 32'(q[0]));
   endtask

   // Drive one cycle of inputs, advance the queue model by the handshake
   // rules, clock once and compare.
   task automatic step(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
      bit inf, outf;
      bus.in_valid  = iv;
      bus.in_data   = id;
      bus.out_ready = ordy;
      flush         = fl;
      inf  = iv && (q.size() < 2);
      outf = ordy && (q.size() > 0);
      if (fl) q.delete();
      else begin
         if (outf) void'(q.pop_front());
         if (inf) q.push_back(id);
      end
      @(posedge clk);
      #1;
      chk_model();
   endtask

   initial begin
      logic       pend_v;
      logic [7:0] pend_d;
      logic       ordy;
      logic       fl;
      bit         accepted;

      rst = 1'b1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready",  32'(bus.in_ready), 1);
      chk("rst_occ",       32'(bus.occupancy), 0);
      chk("rst_out_data",  32'(bus.out_data), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming with out_ready held high.
      step(1, 8'h11, 1, 0); chk("s2_d0", 32'(bus.out_data), 32'h11); chk("s2_occ0", 32'(bus.occupancy), 1);
      step(1, 8'h22, 1, 0); chk("s2_d1", 32'(bus.out_data), 32'h22); chk("s2_rdy1", 32'(bus.in_ready), 1);
      step(1, 8'h33, 1, 0); chk("s2_d2", 32'(bus.out_data), 32'h33); chk("s2_occ2", 32'(bus.occupancy), 1);
      step(0, 8'h00, 1, 0);

      // Fill under backpressure; third word must wait.
      step(1, 8'hA5, 0, 0);
      step(1, 8'h5A, 0, 0); chk("s3_occ", 32'(bus.occupancy), 2); chk("s3_rdy", 32'(bus.in_ready), 0);
      step(1, 8'hFF, 0, 0);
      step(1, 8'hFF, 0, 0); chk("s3_hold", 32'(bus.out_data), 32'hA5); chk("s3_occ_hold", 32'(bus.occupancy), 2);

      // Drain in order with no loss.
      step(1, 8'hFF, 1, 0); chk("s4_d1", 32'(bus.out_data), 32'h5A);
      step(1, 8'hFF, 1, 0); chk("s4_d2", 32'(bus.out_data), 32'hFF);
      step(0, 8'h00, 1, 0); chk("s4_empty", 32'(bus.out_valid), 0);

      // Flush while full with a competing write.
      step(1, 8'h01, 0, 0);
      step(1, 8'h02, 0, 0);
      step(1, 8'h03, 0, 1); chk("s5_occ", 32'(bus.occupancy), 0); chk("s5_valid", 32'(bus.out_valid), 0);
      step(0, 8'h00, 1, 0); chk("s5_no03", 32'(bus.out_valid), 0);
      step(0, 8'h00, 1, 0);

      // Asynchronous reset with held data, mid-cycle.
      step(1, 8'h77, 0, 0);
      step(1, 8'h88, 0, 0);
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      q.delete();
      chk("arst_out_valid", 32'(bus.out_valid), 0);
      chk("arst_out_data",  32'(bus.out_data), 0);
      chk("arst_in_ready",  32'(bus.in_ready), 1);
      chk("arst_occ",       32'(bus.occupancy), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Randomised traffic; upstream holds a word until it is accepted.
      pend_v = 1'b0;
      pend_d = '0;
      for (int i = 0; i < 10000; i++) begin
         if (!pend_v && ($urandom_range(0, 3) != 0)) begin
            pend_v = 1'b1;
            pend_d = 8'($urandom);
         end
         ordy = ($urandom_range(0, 2) != 0);
         fl = ($urandom_range(0, 63) == 0);
         accepted = pend_v && (q.size() < 2);
         step(pend_v, pend_d, ordy, fl);
         chk("rnd_occ_max", 32'(bus.occupancy <= 2'd2), 1);
         if (accepted || fl) pend_v = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
